// File: rtl/mem_bus_master.sv
// Bus initiator for the shared tri-state CS/WE/ADDR/data memory bus.
// Define MEM_BUS_VERIFY_EN to add a readback (VERIFY) pass after every write.
module mem_bus_master #(
  parameter int WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_we,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        CS,
  output logic        WE,
  output logic [31:0] ADDR,
  inout  wire  [31:0] Mem_Bus
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
`ifdef MEM_BUS_VERIFY_EN
    VERIFY = 2'd2,
`endif
    RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cs_q, cs_d;
  logic        weOut_q, weOut_d;
  logic        drv_q, drv_d;
  logic        rspWe_q, rspWe_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef MEM_BUS_VERIFY_EN
  logic        err_q, err_d;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      cs_q    <= 1'b0;
      weOut_q <= 1'b0;
      drv_q   <= 1'b0;
      rspWe_q <= 1'b0;
      rdata_q <= 32'd0;
`ifdef MEM_BUS_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cs_q    <= cs_d;
      weOut_q <= weOut_d;
      drv_q   <= drv_d;
      rspWe_q <= rspWe_d;
      rdata_q <= rdata_d;
`ifdef MEM_BUS_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  // Bus controls are computed one state ahead so CS/WE/drive come straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cs_d    = cs_q;
    weOut_d = weOut_q;
    drv_d   = drv_q;
    rspWe_d = rspWe_q;
    rdata_d = rdata_q;
`ifdef MEM_BUS_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ACCESS;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_CNT;
          cs_d    = 1'b1;
          weOut_d = req_we;
          drv_d   = req_we;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!we_q) begin
          state_d = RESP;
          rdata_d = Mem_Bus;
          rspWe_d = 1'b0;
          cs_d    = 1'b0;
          weOut_d = 1'b0;
          drv_d   = 1'b0;
`ifdef MEM_BUS_VERIFY_EN
          err_d   = 1'b0;
`endif
        end else begin
`ifdef MEM_BUS_VERIFY_EN
          // WE and the driver drop together; CS stays up for the readback.
          state_d = VERIFY;
          cnt_d   = WAIT_CNT;
          weOut_d = 1'b0;
          drv_d   = 1'b0;
`else
          state_d = RESP;
          rdata_d = 32'd0;
          rspWe_d = 1'b1;
          cs_d    = 1'b0;
          weOut_d = 1'b0;
          drv_d   = 1'b0;
`endif
        end
      end
`ifdef MEM_BUS_VERIFY_EN
      VERIFY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          rdata_d = Mem_Bus;
          err_d   = (Mem_Bus != wdata_q);
          rspWe_d = 1'b1;
          cs_d    = 1'b0;
        end
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        weOut_d = 1'b0;
        drv_d   = 1'b0;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE) && !RST;
  assign rsp_valid = (state_q == RESP);
  assign rsp_we    = rspWe_q;
  assign rsp_rdata = rdata_q;
`ifdef MEM_BUS_VERIFY_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign CS        = cs_q;
  assign WE        = weOut_q;
  assign ADDR      = addr_q;
  assign Mem_Bus   = drv_q ? wdata_q : 32'bz;

endmodule
